proc_controller: RTL and testbench

PROC_CONTROLLER -- requirements
Module: proc_controller

---
 rtl/proc_pkg.sv | 63 ++++++
 rtl/prog_counter.sv | 27 ++
 rtl/proc_controller.sv | 152 +++++++++++++++
 tb/tb_proc_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction-sequencing controller and its ALU.
//   state_t      : FSM state encoding, also exposed on the State debug port
//   OP_*         : instruction opcodes (IR[15:12])
//   ALU_*        : ALU function-select encodings
//   is_alu_op    : true for opcodes executed in the single ALU_OP state
//   alu_sel_of   : opcode -> ALU function select
package proc_pkg;

   // INIT is encoded as zero so that the reset value of the state register
   // and of the State debug port is all-zeros.
   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_NOOP   = 4'd3,
      ST_LOAD_A = 4'd4,
      ST_LOAD_B = 4'd5,
      ST_STORE  = 4'd6,
      ST_ALU_OP = 4'd7,
      ST_HALT   = 4'd8
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_OR    = 4'h7;
   localparam logic [3:0] OP_AND   = 4'h8;
   localparam logic [3:0] OP_INC   = 4'h9;

   localparam logic [2:0] ALU_ZERO   = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b001;
   localparam logic [2:0] ALU_SUB    = 3'b010;
   localparam logic [2:0] ALU_PASS_A = 3'b011;
   localparam logic [2:0] ALU_XOR    = 3'b100;
   localparam logic [2:0] ALU_OR     = 3'b101;
   localparam logic [2:0] ALU_AND    = 3'b110;
   localparam logic [2:0] ALU_INC    = 3'b111;

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
             (op == OP_OR)  || (op == OP_AND) || (op == OP_INC);
   endfunction

   function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
      logic [2:0] sel;
      sel = ALU_ZERO;
      case (op)
         OP_ADD:  sel = ALU_ADD;
         OP_SUB:  sel = ALU_SUB;
         OP_XOR:  sel = ALU_XOR;
         OP_OR:   sel = ALU_OR;
         OP_AND:  sel = ALU_AND;
         OP_INC:  sel = ALU_INC;
         default: sel = ALU_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter for the controller.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset, clears pc
//   clear : synchronous clear to 0 (has priority over incr)
//   incr  : advance pc by one, wrapping from all-ones to 0
//   pc    : current program counter
module prog_counter #(
   parameter int PC_W = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            incr,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (clear) begin
         pc <= '0;
      end else if (incr) begin
         pc <= pc + PC_W'(1);   // natural modulo-2^PC_W wrap
      end
   end

endmodule

// File: rtl/proc_controller.sv
// Multi-cycle instruction sequencer: fetches 16-bit instructions from an
// instruction ROM and drives data-memory, register-file and ALU controls.
//   Clk, ResetN            : clock / asynchronous active-low reset
//   I_Data                 : ROM word at I_Addr (one-cycle read latency)
//   I_Addr                 : current PC
//   D_Addr, D_Wr           : data-memory address and write strobe
//   RF_s                   : register-file write source (1 = memory, 0 = ALU)
//   RF_W_Addr, RF_W_En     : register-file write port
//   RF_Ra_Addr, RF_Rb_Addr : register-file read ports feeding ALU A / B
//   ALU_Sel                : ALU function select
//   State                  : FSM state (debug)
//   Halted                 : high exactly while in HALT
module proc_controller
   import proc_pkg::*;
#(
   parameter int         PC_W    = 7,
   parameter logic [3:0] HALT_OP = OP_HALT
) (
   input  logic            Clk,
   input  logic            ResetN,
   input  logic [15:0]     I_Data,
   output logic [PC_W-1:0] I_Addr,
   output logic [7:0]      D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_Addr,
   output logic            RF_W_En,
   output logic [3:0]      RF_Ra_Addr,
   output logic [3:0]      RF_Rb_Addr,
   output logic [2:0]      ALU_Sel,
   output logic [3:0]      State,
   output logic            Halted
);

   state_t      state;
   logic [15:0] ir;
   logic        pc_clear;
   logic        pc_incr;

   // Instruction fields
   logic [3:0] op;
   logic [3:0] alu_rq;
   logic [3:0] alu_ra;
   logic [3:0] alu_rb;
   logic [7:0] mem_addr;
   logic [3:0] mem_rq;

   assign op       = ir[15:12];
   assign alu_rq   = ir[11:8];
   assign alu_ra   = ir[7:4];
   assign alu_rb   = ir[3:0];
   assign mem_addr = ir[11:4];
   assign mem_rq   = ir[3:0];

   assign pc_clear = (state == ST_INIT);
   assign pc_incr  = (state == ST_FETCH);
   assign State    = state;

   prog_counter #(
      .PC_W (PC_W)
   ) u_pc (
      .clk   (Clk),
      .rst_n (ResetN),
      .clear (pc_clear),
      .incr  (pc_incr),
      .pc    (I_Addr)
   );

   // Outputs are registered alongside the state: each branch loads the
   // values belonging to the state being entered, so outputs change only
   // on the clock edge together with State (Moore timing, no glitches).
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state      <= ST_INIT;
         ir         <= '0;
         D_Addr     <= '0;
         D_Wr       <= 1'b0;
         RF_s       <= 1'b0;
         RF_W_Addr  <= '0;
         RF_W_En    <= 1'b0;
         RF_Ra_Addr <= '0;
         RF_Rb_Addr <= '0;
         ALU_Sel    <= ALU_ZERO;
         Halted     <= 1'b0;
      end else begin
         D_Addr     <= '0;
         D_Wr       <= 1'b0;
         RF_s       <= 1'b0;
         RF_W_Addr  <= '0;
         RF_W_En    <= 1'b0;
         RF_Ra_Addr <= '0;
         RF_Rb_Addr <= '0;
         ALU_Sel    <= ALU_ZERO;
         Halted     <= 1'b0;

         case (state)
            ST_INIT: begin
               state <= ST_FETCH;
            end
            ST_FETCH: begin
               ir    <= I_Data;
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               // HALT_OP is checked first so a retargeted halt opcode
               // overrides whatever that opcode would otherwise do.
               if (op == HALT_OP) begin
                  state  <= ST_HALT;
                  Halted <= 1'b1;
               end else if (op == OP_STORE) begin
                  state      <= ST_STORE;
                  D_Addr     <= mem_addr;
                  RF_Ra_Addr <= mem_rq;
                  ALU_Sel    <= ALU_PASS_A;
                  D_Wr       <= 1'b1;
               end else if (op == OP_LOAD) begin
                  state     <= ST_LOAD_A;
                  D_Addr    <= mem_addr;
                  RF_s      <= 1'b1;
                  RF_W_Addr <= mem_rq;
               end else if (is_alu_op(op)) begin
                  state      <= ST_ALU_OP;
                  RF_Ra_Addr <= alu_ra;
                  RF_Rb_Addr <= alu_rb;
                  RF_W_Addr  <= alu_rq;
                  RF_W_En    <= 1'b1;
                  ALU_Sel    <= alu_sel_of(op);
               end else begin
                  state <= ST_NOOP;
               end
            end
            ST_LOAD_A: begin
               // Memory read data is valid by now; commit it in LOAD_B.
               state     <= ST_LOAD_B;
               D_Addr    <= mem_addr;
               RF_s      <= 1'b1;
               RF_W_Addr <= mem_rq;
               RF_W_En   <= 1'b1;
            end
            ST_HALT: begin
               state  <= ST_HALT;
               Halted <= 1'b1;
            end
            default: begin
               // NOOP, LOAD_B, STORE, ALU_OP and any stray encoding.
               state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_controller.sv
module tb_proc_controller;
   import proc_pkg::*;

   typedef struct packed {
      logic [3:0] state;
      logic [6:0] i_addr;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] w_addr;
      logic       w_en;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
      logic       halted;
   } outs_t;

   typedef struct {
      string      name;
      logic [15:0] instr;
      outs_t      exp;
      bit         two_cycle;
   } vec_t;

   typedef struct {
      string tag;
      outs_t exp;
   } sb_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] i_data;
   logic [6:0]  i_addr;
   logic [7:0]  d_addr;
   logic        d_wr;
   logic        rf_s;
   logic [3:0]  rf_w_addr;
   logic        rf_w_en;
   logic [3:0]  rf_ra_addr;
   logic [3:0]  rf_rb_addr;
   logic [2:0]  alu_sel;
   logic [3:0]  state_dbg;
   logic        halted;

   logic [15:0] rom [0:127];

   int checks = 0;
   int errors = 0;
   sb_t sb_q[$];
   vec_t vecs[11];

   proc_controller #(.PC_W(7), .HALT_OP(4'h5)) dut (
      .Clk        (clk),
      .ResetN     (rst_n),
      .I_Data     (i_data),
      .I_Addr     (i_addr),
      .D_Addr     (d_addr),
      .D_Wr       (d_wr),
      .RF_s       (rf_s),
      .RF_W_Addr  (rf_w_addr),
      .RF_W_En    (rf_w_en),
      .RF_Ra_Addr (rf_ra_addr),
      .RF_Rb_Addr (rf_rb_addr),
      .ALU_Sel    (alu_sel),
      .State      (state_dbg),
      .Halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data for an address appears one cycle later.
   always @(posedge clk) i_data <= rom[i_addr];

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic outs_t sample();
      outs_t o;
      o = '{state_dbg, i_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
            rf_ra_addr, rf_rb_addr, alu_sel, halted};
      return o;
   endfunction

   function automatic outs_t mk(input logic [3:0] s, input logic [7:0] da,
                                input logic dw, input logic rs,
                                input logic [3:0] wa, input logic we,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [2:0] alu);
      outs_t o;
      o = '{s, 7'd1, da, dw, rs, wa, we, ra, rb, alu, 1'b0};
      return o;
   endfunction

   // Idle record: only state, PC and Halted may be non-zero.
   function automatic outs_t idle(input logic [3:0] s, input logic [6:0] ia,
                                  input logic h);
      outs_t o;
      o = '0;
      o.state  = s;
      o.i_addr = ia;
      o.halted = h;
      return o;
   endfunction

   task automatic check(input string tag, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end else begin
         $display("ok   %s outs=%h", tag, act);
      end
   endtask

   task automatic push(input string tag, input outs_t e);
      sb_t s;
      s.tag = tag;
      s.exp = e;
      sb_q.push_back(s);
   endtask

   task automatic pop_check();
      sb_t s;
      @(negedge clk);
      s = sb_q.pop_front();
      check(s.tag, sample(), s.exp);
   endtask

   task automatic drain();
      while (sb_q.size() > 0) pop_check();
   endtask

   task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1);
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
      rom[0] = w0;
      rom[1] = w1;
   endtask

   // Hold reset across one sampling edge, check the reset state, release.
   task automatic reset_phase(input string name);
      rst_n = 1'b0;
      push({name, "_reset"}, '0);
      pop_check();
      rst_n = 1'b1;
   endtask

   // Run until State equals target, at most max_cycles sampling edges.
   task automatic wait_state(input logic [3:0] target, input int max_cycles,
                             input string name, output bit found);
      found = 1'b0;
      for (int c = 0; c < max_cycles && !found; c++) begin
         @(negedge clk);
         if (state_dbg == target) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s_reach got state %0d expected %0d", name, state_dbg, target);
      end
   endtask

   // Assert reset asynchronously while the instruction is in target state.
   task automatic abort_test(input string name, input logic [15:0] instr,
                             input logic [3:0] target);
      bit found;
      load_rom(instr, 16'h0000);
      reset_phase(name);
      wait_state(target, 10, name, found);
      #2 rst_n = 1'b0;
      #1 check({name, "_async"}, sample(), '0);
      for (int k = 0; k < 3; k++) push({name, "_hold"}, '0);
      drain();
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      rst_n = 1'b0;
      load_rom(16'h0000, 16'h0000);

      vecs[0]  = '{"add",   16'h3123, mk(ST_ALU_OP, 8'h00, 0, 0, 4'h1, 1, 4'h2, 4'h3, 3'b001), 1'b0};
      vecs[1]  = '{"sub",   16'h4A5B, mk(ST_ALU_OP, 8'h00, 0, 0, 4'hA, 1, 4'h5, 4'hB, 3'b010), 1'b0};
      vecs[2]  = '{"xor",   16'h6012, mk(ST_ALU_OP, 8'h00, 0, 0, 4'h0, 1, 4'h1, 4'h2, 3'b100), 1'b0};
      vecs[3]  = '{"or",    16'h7FED, mk(ST_ALU_OP, 8'h00, 0, 0, 4'hF, 1, 4'hE, 4'hD, 3'b101), 1'b0};
      vecs[4]  = '{"and",   16'h8345, mk(ST_ALU_OP, 8'h00, 0, 0, 4'h3, 1, 4'h4, 4'h5, 3'b110), 1'b0};
      vecs[5]  = '{"inc",   16'h9670, mk(ST_ALU_OP, 8'h00, 0, 0, 4'h6, 1, 4'h7, 4'h0, 3'b111), 1'b0};
      vecs[6]  = '{"load",  16'h21A4, mk(ST_LOAD_A, 8'h1A, 0, 1, 4'h4, 0, 4'h0, 4'h0, 3'b000), 1'b1};
      vecs[7]  = '{"store", 16'h1055, mk(ST_STORE,  8'h05, 1, 0, 4'h0, 0, 4'h5, 4'h0, 3'b011), 1'b0};
      vecs[8]  = '{"noop",  16'h0000, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000), 1'b0};
      vecs[9]  = '{"opF",   16'hF000, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000), 1'b0};
      vecs[10] = '{"opA",   16'hA123, mk(ST_NOOP,   8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000), 1'b0};

      repeat (2) @(negedge clk);

      // Table: one instruction at address 0 followed by HALT at address 1.
      for (int v = 0; v < 11; v++) begin
         outs_t e2;
         load_rom(vecs[v].instr, 16'h5000);
         reset_phase(vecs[v].name);
         push({vecs[v].name, "_fetch"},  idle(ST_FETCH, 7'd0, 1'b0));
         push({vecs[v].name, "_decode"}, idle(ST_DECODE, 7'd1, 1'b0));
         push({vecs[v].name, "_exec"},   vecs[v].exp);
         if (vecs[v].two_cycle) begin
            e2 = vecs[v].exp;
            e2.state = ST_LOAD_B;
            e2.w_en  = 1'b1;
            push({vecs[v].name, "_exec2"}, e2);
         end
         push({vecs[v].name, "_fetch1"},  idle(ST_FETCH, 7'd1, 1'b0));
         push({vecs[v].name, "_decode1"}, idle(ST_DECODE, 7'd2, 1'b0));
         push({vecs[v].name, "_halt"},    idle(ST_HALT, 7'd2, 1'b1));
         drain();
      end

      // HALT at address 0: PC frozen at 1 for 20+ cycles, then reset pulse.
      load_rom(16'h5000, 16'h3123);
      reset_phase("halt");
      push("halt_fetch",  idle(ST_FETCH, 7'd0, 1'b0));
      push("halt_decode", idle(ST_DECODE, 7'd1, 1'b0));
      for (int k = 0; k < 21; k++) push("halt_hold", idle(ST_HALT, 7'd1, 1'b1));
      drain();
      #2 rst_n = 1'b0;
      #1 check("halt_async_reset", sample(), '0);
      push("halt_rst_hold", '0);
      drain();
      rst_n = 1'b1;
      push("halt_refetch", idle(ST_FETCH, 7'd0, 1'b0));
      push("halt_redecode", idle(ST_DECODE, 7'd1, 1'b0));
      drain();

      // PC wrap: all-NOOP ROM, fetch at 127 must advance I_Addr to 0.
      load_rom(16'h0000, 16'h0000);
      reset_phase("wrap");
      found = 1'b0;
      for (int c = 0; c < 600 && !found; c++) begin
         @(negedge clk);
         if (state_dbg == ST_FETCH && i_addr == 7'd127) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL wrap_reach got pc %0d expected 127", i_addr);
      end else begin
         push("wrap_decode", idle(ST_DECODE, 7'd0, 1'b0));
         push("wrap_noop",   idle(ST_NOOP, 7'd0, 1'b0));
         push("wrap_fetch",  idle(ST_FETCH, 7'd0, 1'b0));
         drain();
      end

      // Reset mid-instruction must suppress the pending strobe.
      abort_test("abort_load_a", 16'h21A4, ST_LOAD_A);
      abort_test("abort_load_b", 16'h21A4, ST_LOAD_B);
      abort_test("abort_store",  16'h1055, ST_STORE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
